// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default stage indices for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Default stage layout of the five-stage in-order pipe.
    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_DEC_STAGE  = 1;
    localparam int DEF_EX_STAGE   = 2;
    localparam int DEF_MEM_STAGE  = 3;

    // RUN is normal operation; DRAIN means one stale fetch is still in flight.
    typedef enum logic {
        RUN,
        DRAIN
    } pipe_ctrl_state_e;

    // The condition that won the per-cycle priority decode.
    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_DMEM,
        CAUSE_FLUSH,
        CAUSE_LOADUSE,
        CAUSE_IMEM
    } pipe_ctrl_cause_e;

endpackage

// File: rtl/pipe_valid_shift.sv
// Per-stage valid shift register. Each stage either holds, is cleared
// (kill or bubble), or takes the value shifted in from the previous stage.
// Stages up to FILL_UPTO are the front end and become valid whenever they load.
module pipe_valid_shift #(
    parameter int NUM_STAGES = 5,
    parameter int FILL_UPTO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] hold,
    input  logic [NUM_STAGES-1:0] kill,
    input  logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] valid
);

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic shift_in;
        if (i <= FILL_UPTO) begin : g_fill
            assign shift_in = 1'b1;
        end else begin : g_chain
            assign shift_in = valid[i-1];
        end

        // Update one stage's valid bit: hold, clear, or shift.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid[i] <= 1'b0;
            end else if (!hold[i]) begin
                valid[i] <= (kill[i] | bubble[i]) ? 1'b0 : shift_in;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the in-order pipe: derives per-stage register
// load enables and valid bits from memory handshakes, load-use hazards and
// branch redirects. Optional perf counters are built when PIPE_CTRL_PERF_EN
// is defined.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int DEC_STAGE  = DEF_DEC_STAGE,
    parameter int EX_STAGE   = DEF_EX_STAGE,
    parameter int MEM_STAGE  = DEF_MEM_STAGE,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic                  dmem_resp,
    input  logic                  load_use,
    input  logic                  flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0]      cnt_dmem_stall,
    output logic [CNT_W-1:0]      cnt_imem_stall,
    output logic [CNT_W-1:0]      cnt_bubble,
    output logic [CNT_W-1:0]      cnt_flush,
`endif
    output logic [NUM_STAGES-1:0] load,
    output logic [NUM_STAGES-1:0] valid,
    output logic                  stall_dmem,
    output logic                  stall_imem
);

    pipe_ctrl_state_e state, state_next;
    pipe_ctrl_cause_e cause;
    logic             dmem_busy;
    logic [NUM_STAGES-1:0] kill, bubble;

    // A memory-stage access only stalls when the stage holds a real instruction.
    assign dmem_busy = valid[MEM_STAGE] & (dmem_read | dmem_write) & ~dmem_resp;

    // Priority decode: dmem freeze, redirect, load-use bubble, fetch wait, normal.
    always_comb begin
        load       = '0;
        kill       = '0;
        bubble     = '0;
        stall_dmem = 1'b0;
        stall_imem = 1'b0;
        cause      = CAUSE_NONE;
        state_next = state;
        if (rst) begin
            cause = CAUSE_NONE;
        end else if (dmem_busy) begin
            cause      = CAUSE_DMEM;
            stall_dmem = 1'b1;
        end else if (flush) begin
            cause = CAUSE_FLUSH;
            load  = '1;
            for (int i = 1; i <= EX_STAGE; i++) kill[i] = 1'b1;
            // The redirected fetch is outstanding unless it returned this cycle
            // into a clean pipe; an existing stale fetch keeps us draining.
            state_next = (!imem_resp || state == DRAIN) ? DRAIN : RUN;
        end else if (load_use) begin
            cause = CAUSE_LOADUSE;
            load  = '1;
            for (int i = 0; i <= DEC_STAGE; i++) load[i] = 1'b0;
            bubble[EX_STAGE] = 1'b1;
            if (state == DRAIN && imem_resp) state_next = RUN;
        end else if (!imem_resp || state == DRAIN) begin
            cause      = CAUSE_IMEM;
            load       = '1;
            load[0]    = 1'b0;
            stall_imem = 1'b1;
            bubble[DEC_STAGE] = 1'b1;
            // The stale response is discarded here; the next one is real.
            if (state == DRAIN && imem_resp) state_next = RUN;
        end else begin
            load = '1;
        end
    end

    // Redirect drain state register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // A stage that is not loaded keeps its valid bit.
    pipe_valid_shift #(
        .NUM_STAGES (NUM_STAGES),
        .FILL_UPTO  (DEC_STAGE)
    ) u_valid (
        .clk    (clk),
        .rst    (rst),
        .hold   (~load),
        .kill   (kill),
        .bubble (bubble),
        .valid  (valid)
    );

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Count the cycles in which each stall cause wins the priority decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_dmem_stall <= '0;
            cnt_imem_stall <= '0;
            cnt_bubble     <= '0;
            cnt_flush      <= '0;
        end else begin
            case (cause)
                CAUSE_DMEM:    cnt_dmem_stall <= sat_inc(cnt_dmem_stall);
                CAUSE_IMEM:    cnt_imem_stall <= sat_inc(cnt_imem_stall);
                CAUSE_LOADUSE: cnt_bubble     <= sat_inc(cnt_bubble);
                CAUSE_FLUSH:   cnt_flush      <= sat_inc(cnt_flush);
                default:       ;
            endcase
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with the default 5-stage layout.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_resp = 1'b0, dmem_read = 1'b0, dmem_write = 1'b0;
    logic       dmem_resp = 1'b0, load_use = 1'b0, flush = 1'b0;
    logic [4:0] load, valid;
    logic       stall_dmem, stall_imem;
`ifdef PIPE_CTRL_PERF_EN
    logic [3:0] cnt_dmem_stall, cnt_imem_stall, cnt_bubble, cnt_flush;
`endif

    int checks   = 0;
    int failures = 0;

    // Input bit positions: {imem_resp, dmem_read, dmem_write, dmem_resp, load_use, flush}
    localparam logic [5:0] IM = 6'b100000;
    localparam logic [5:0] RD = 6'b010000;
    localparam logic [5:0] WR = 6'b001000;
    localparam logic [5:0] RS = 6'b000100;
    localparam logic [5:0] LU = 6'b000010;
    localparam logic [5:0] FL = 6'b000001;
    localparam logic [4:0] ALL = 5'b11111;

    pipeline_ctrl #(.CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_resp      (imem_resp),
        .dmem_read      (dmem_read),
        .dmem_write     (dmem_write),
        .dmem_resp      (dmem_resp),
        .load_use       (load_use),
        .flush          (flush),
`ifdef PIPE_CTRL_PERF_EN
        .cnt_dmem_stall (cnt_dmem_stall),
        .cnt_imem_stall (cnt_imem_stall),
        .cnt_bubble     (cnt_bubble),
        .cnt_flush      (cnt_flush),
`endif
        .load           (load),
        .valid          (valid),
        .stall_dmem     (stall_dmem),
        .stall_imem     (stall_imem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs, clock, check valid.
    task automatic cyc(input string tag, input logic [5:0] in, input logic [4:0] e_load,
                       input logic e_sd, input logic e_si, input logic [4:0] e_valid);
        {imem_resp, dmem_read, dmem_write, dmem_resp, load_use, flush} = in;
        #1;
        check({tag, ".load"}, 32'(load), 32'(e_load));
        check({tag, ".stall_dmem"}, 32'(stall_dmem), 32'(e_sd));
        check({tag, ".stall_imem"}, 32'(stall_imem), 32'(e_si));
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    endtask

    // Four normal cycles fill the pipe from any state.
    task automatic fill(input string tag);
        {imem_resp, dmem_read, dmem_write, dmem_resp, load_use, flush} = IM;
        repeat (4) @(posedge clk);
        #1;
        check({tag, ".fill"}, 32'(valid), 32'(ALL));
    endtask

    initial begin
        // Reset: outputs quiet regardless of inputs.
        rst = 1'b1;
        cyc("rst0", 6'b0, 5'b0, 1'b0, 1'b0, 5'b0);
        cyc("rst1", IM | RD | FL, 5'b0, 1'b0, 1'b0, 5'b0);
        rst = 1'b0;

        // Fill from empty.
        cyc("fill1", IM, ALL, 1'b0, 1'b0, 5'b00011);
        cyc("fill2", IM, ALL, 1'b0, 1'b0, 5'b00111);
        cyc("fill3", IM, ALL, 1'b0, 1'b0, 5'b01111);
        cyc("fill4", IM, ALL, 1'b0, 1'b0, 5'b11111);
        cyc("fill5", IM, ALL, 1'b0, 1'b0, 5'b11111);

        // Data-memory wait freezes everything for exactly three cycles.
        for (int i = 0; i < 3; i++) cyc("dbusy", IM | RD, 5'b0, 1'b1, 1'b0, ALL);
        cyc("dresp", IM | RD | RS, ALL, 1'b0, 1'b0, ALL);
        cyc("dwr", IM | WR, 5'b0, 1'b1, 1'b0, ALL);
        cyc("dwr_resp", IM | WR | RS, ALL, 1'b0, 1'b0, ALL);

        // Load-use bubble, then decode instruction moves into EX.
        cyc("lu", IM | LU, 5'b11100, 1'b0, 1'b0, 5'b11011);
        cyc("lu_after", IM, ALL, 1'b0, 1'b0, 5'b10111);
        fill("lu");

        // Fetch wait inserts a decode bubble.
        cyc("fw", 6'b0, 5'b11110, 1'b0, 1'b1, 5'b11101);
        fill("fw");

        // Flush with no fetch response enters DRAIN; next response discarded.
        cyc("fl", FL, ALL, 1'b0, 1'b0, 5'b11001);
        cyc("drain", IM, 5'b11110, 1'b0, 1'b1, 5'b10001);
        cyc("run_rd_ign", IM | RD, ALL, 1'b0, 1'b0, 5'b00011);
        fill("fl");

        // A flush while draining keeps draining.
        cyc("fl2", FL, ALL, 1'b0, 1'b0, 5'b11001);
        cyc("fl2_drain", IM | FL, ALL, 1'b0, 1'b0, 5'b10001);
        cyc("fl2_disc", IM, 5'b11110, 1'b0, 1'b1, 5'b00001);
        cyc("fl2_run", IM, ALL, 1'b0, 1'b0, 5'b00011);
        fill("fl2");

        // Flush and load-use during a dmem stall: nothing happens until resp.
        cyc("bfl", IM | RD | FL | LU, 5'b0, 1'b1, 1'b0, ALL);
        cyc("bfl_resp", IM | RD | RS | FL | LU, ALL, 1'b0, 1'b0, 5'b11001);
        cyc("bfl_after", IM, ALL, 1'b0, 1'b0, 5'b10011);
        fill("bfl");

        // Reset in the middle of a dmem stall abandons it.
        cyc("rs_busy", IM | RD, 5'b0, 1'b1, 1'b0, ALL);
        rst = 1'b1;
        cyc("rs_rst", IM | RD, 5'b0, 1'b0, 1'b0, 5'b0);
        rst = 1'b0;
        cyc("rs_rel", IM | RD, ALL, 1'b0, 1'b0, 5'b00011);
        fill("rs");

        // Reset in the middle of DRAIN returns to RUN.
        cyc("rd_fl", FL, ALL, 1'b0, 1'b0, 5'b11001);
        rst = 1'b1;
        cyc("rd_rst", IM, 5'b0, 1'b0, 1'b0, 5'b0);
        rst = 1'b0;
        cyc("rd_rel", IM, ALL, 1'b0, 1'b0, 5'b00011);

`ifdef PIPE_CTRL_PERF_EN
        // Counters: reset to zero, saturate at 15 with CNT_W=4.
        rst = 1'b1;
        cyc("p_rst", 6'b0, 5'b0, 1'b0, 1'b0, 5'b0);
        check("p_rst.dmem", 32'(cnt_dmem_stall), 32'd0);
        check("p_rst.flush", 32'(cnt_flush), 32'd0);
        check("p_rst.bubble", 32'(cnt_bubble), 32'd0);
        check("p_rst.imem", 32'(cnt_imem_stall), 32'd0);
        rst = 1'b0;
        fill("p");
        for (int i = 0; i < 20; i++) cyc("p_busy", IM | RD, 5'b0, 1'b1, 1'b0, ALL);
        check("p_sat.dmem", 32'(cnt_dmem_stall), 32'd15);
        check("p_sat.imem", 32'(cnt_imem_stall), 32'd0);
        rst = 1'b1;
        cyc("p_rst2", IM | RD, 5'b0, 1'b0, 1'b0, 5'b0);
        check("p_rst2.dmem", 32'(cnt_dmem_stall), 32'd0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised stall/flush controller for the in-order RISC-V pipeline. It generates per-stage pipeline-register load enables and per-stage valid bits from instruction-memory and data-memory handshakes, load-use hazards and branch redirects. It freezes the whole pipe on data-memory wait, inserts bubbles on fetch wait and load-use, and squashes younger stages on redirect. It sits beside the datapath and drives every stage register's load input.

## Interface
- NUM_STAGES, 5, number of stages (≥4); stage 0 = fetch, stage i register feeds stage i
- DEC_STAGE, 1, index of decode stage
- EX_STAGE, 2, index of execute stage (branch resolution, load-use source)
- MEM_STAGE, 3, index of memory stage (data access)
- CNT_W, 32, width of performance counters (PIPE_CTRL_PERF_EN only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_resp  in  1  fetch data valid this cycle
- dmem_read  in  1  memory stage issuing load
- dmem_write  in  1  memory stage issuing store
- dmem_resp  in  1  data access complete this cycle
- load_use  in  1  decode instruction consumes the result of a load in EX
- flush  in  1  redirect resolved in EX this cycle
- load  out  NUM_STAGES  load[0] = PC enable; load[i] = enable of register feeding stage i
- valid  out  NUM_STAGES  registered valid bit per stage
- stall_dmem  out  1  pipe frozen on data memory
- stall_imem  out  1  fetch bubble this cycle

## Operation
- dmem_busy = valid[MEM_STAGE] & (dmem_read | dmem_write) & ~dmem_resp.
- Priority per cycle, highest first: rst, dmem_busy, flush, load_use, fetch wait, normal.
- dmem_busy: load all 0; valid holds; state holds; stall_dmem=1.
- flush: load all 1. valid[i] next = 0 for 1 ≤ i ≤ EX_STAGE. valid[i] for i > EX_STAGE shifts normally (valid[i] ← valid[i-1]). If imem_resp=0 that cycle, state → DRAIN.
- load_use (no flush): load[0..DEC_STAGE]=0; load[EX_STAGE..]=1; valid[EX_STAGE] next = 0 (bubble); later stages shift.
- Fetch wait (imem_resp=0, or state DRAIN): load[0]=0; other loads 1; valid[DEC_STAGE] next = 0; stall_imem=1.
- Normal: load all 1; valid[i] ← valid[i-1]; valid[DEC_STAGE] ← 1.
- FSM has two states:
  - RUN: default.
  - DRAIN: one stale fetch is in flight after a redirect. The next imem_resp is discarded and treated as fetch wait (PC does not load), then state → RUN. A flush in DRAIN keeps DRAIN.
- valid[0] is 0 in the reset cycle and 1 from the next cycle onward.
- dmem_read/dmem_write are ignored when valid[MEM_STAGE]=0.

## Timing
- load, stall_dmem and stall_imem are combinational from inputs, state and valid (same cycle, no latency).
- valid and state update on posedge clk.
- Reset values: valid=0, state=RUN, counters=0. While rst=1, load=0, stall_dmem=0, stall_imem=0.
- Reset mid-stall or mid-DRAIN abandons the stall unconditionally.
- dmem_resp arriving in the same cycle as a request: no stall.
- flush during dmem_busy is ignored. The EX stage holds the branch, so it re-asserts flush after the pipe unfreezes.
- flush together with load_use: flush wins; no bubble beyond the squash.
- Data in flight down the pipe reaches stage k exactly k-1 un-frozen cycles after leaving decode.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs cnt_dmem_stall, cnt_imem_stall, cnt_bubble and cnt_flush, each CNT_W bits.
  - Each counts cycles where its condition is selected by the priority rules.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and all their logic are absent; all other behaviour is identical.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum pipe_ctrl_state_e {RUN, DRAIN};
  - default stage-index constants;
  - stall-cause enum {CAUSE_NONE, CAUSE_DMEM, CAUSE_FLUSH, CAUSE_LOADUSE, CAUSE_IMEM}.
- One sub-module, pipe_valid_shift: a parametrised valid shift register with per-stage hold, kill and bubble inputs.
- Priority decode and the FSM stay in pipeline_ctrl.

## Test plan
- Reset, then imem_resp=1 for 5 cycles, other inputs 0 -> load=5'b11111 each cycle; valid fills to 5'b11111 by cycle 5.
- Full pipe, dmem_read=1, dmem_resp=0 for 3 cycles then 1 -> load=0 and valid frozen for 3 cycles; load=5'b11111 on the resp cycle; stall_dmem high for exactly 3 cycles.
- load_use=1 for 1 cycle -> load=5'b11100; valid[2] next 0; the decode instruction re-presents in EX the following cycle.
- flush=1 with imem_resp=0 -> valid[1], valid[2] next 0; state DRAIN. Next imem_resp=1 is discarded (load[0]=0), then RUN.
- flush and load_use together during dmem_busy -> all loads 0, nothing squashed. Next cycle with dmem_resp=1 -> flush takes effect.
- With PIPE_CTRL_PERF_EN and CNT_W=4, hold dmem stall 20 cycles -> cnt_dmem_stall saturates at 15. rst -> all counters 0.
